// File: rtl/mem_scan.sv
// Scans every word of a synchronous-read memory once per start request and
// reports the unsigned sum and maximum through a valid/ready result port.
module mem_scan #(
  parameter int unsigned AW = 3,
  parameter int unsigned DW = 16
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  output logic [AW-1:0]    addr_o,
  input  logic [DW-1:0]    rd_data_i,
  output logic             busy_o,
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic [DW+AW-1:0] sum_o,
  output logic [DW-1:0]    max_o
);

  typedef enum logic [1:0] {StIdle, StIssue, StDrain, StHold} state_e;

  localparam logic [AW-1:0] AddrLast = {AW{1'b1}};

  state_e           state_q, state_d;
  logic [AW-1:0]    addr_q, addr_d, addr_inc;
  logic             drain_q, drain_d;
  logic [DW+AW-1:0] sum_q, sum_d;
  logic [DW-1:0]    max_q, max_d;
  logic             capture;

  assign addr_inc = addr_q + AW'(1);

  // Read data for address k arrives two edges after k was issued, so the first
  // capture happens once addr has moved past 0 and the last in the second drain cycle.
  assign capture = ((state_q == StIssue) && (addr_q != '0)) || (state_q == StDrain);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    drain_d = drain_q;
    sum_d   = sum_q;
    max_d   = max_q;

    if (capture) begin
      sum_d = sum_q + (DW+AW)'(rd_data_i);
      if (rd_data_i > max_q) begin
        max_d = rd_data_i;
      end
    end

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d = StIssue;
          addr_d  = '0;
          sum_d   = '0;
          max_d   = '0;
        end
      end
      StIssue: begin
        addr_d = addr_inc;
        if (addr_inc == AddrLast) begin
          state_d = StDrain;
          drain_d = 1'b0;
        end
      end
      StDrain: begin
        drain_d = 1'b1;
        if (drain_q) begin
          state_d = StHold;
        end
      end
      StHold: begin
        if (res_ready_i) begin
          state_d = StIdle;
          addr_d  = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= StIdle;
      addr_q  <= '0;
      drain_q <= 1'b0;
      sum_q   <= '0;
      max_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      drain_q <= drain_d;
      sum_q   <= sum_d;
      max_q   <= max_d;
    end
  end

  assign addr_o      = addr_q;
  assign busy_o      = (state_q == StIssue) || (state_q == StDrain);
  assign res_valid_o = (state_q == StHold);
  assign sum_o       = sum_q;
  assign max_o       = max_q;

endmodule

// File: doc/mem_scan.md
MEM_SCAN -- requirements
Module: mem_scan

Interface
REQ-001 Parameter AW, default 3, memory address width; depth = 2^AW words.
REQ-002 Parameter DW, default 16, memory data width.
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  scan request; sampled only in IDLE.
REQ-006 addr  output  AW  read address driven to the memory's read-address port; registered.
REQ-007 rd_data  input  DW  memory read data; valid one clock after addr is presented (synchronous-read memory).
REQ-008 busy  output  1  high while a scan is issuing or draining reads.
REQ-009 res_valid  output  1  result available; held until accepted.
REQ-010 res_ready  input  1  consumer accepts result when res_valid && res_ready at a rising edge.
REQ-011 sum  output  DW+AW  unsigned sum of all 2^AW words of the last scan.
REQ-012 max  output  DW  unsigned maximum of all 2^AW words of the last scan.

Function
REQ-013 FSM states: IDLE, ISSUE, DRAIN, HOLD; DRAIN lasts exactly 2 cycles.
REQ-014 IDLE: start=1 at edge E0 -> ISSUE, addr=0, busy=1, sum/max accumulators cleared to 0.
REQ-015 ISSUE: addr increments by 1 each edge; at the edge where addr equals 2^AW-1 -> DRAIN, addr holds at 2^AW-1.
REQ-016 Word read at address k is accumulated at edge E(k+2): sum += zero-extended rd_data; max = rd_data if rd_data > max.
REQ-017 DRAIN: after its second edge E(2^AW+1) -> HOLD; busy=0 and res_valid=1 from that edge (latency 2^AW+1 cycles from start edge; 9 cycles at AW=3).
REQ-018 HOLD: sum, max, res_valid stable while res_ready=0.
REQ-019 HOLD with res_valid && res_ready at an edge -> IDLE, res_valid=0, addr=0; sum/max keep last values until next start.
REQ-020 start while in ISSUE, DRAIN or HOLD is ignored (no queueing); start in the handshake cycle is ignored, accepted earliest the following cycle.
REQ-021 sum width DW+AW; no overflow possible; no wrap of addr beyond 2^AW-1 within a scan.
REQ-022 rd_data is not sampled outside the 2^AW capture edges; X or changing rd_data elsewhere has no effect.
REQ-023 res_ready while not in HOLD has no effect.

Reset
REQ-024 reset=1 at an edge forces IDLE, addr=0, busy=0, res_valid=0, sum=0, max=0, overriding all other inputs.
REQ-025 reset mid-scan (ISSUE/DRAIN) or in HOLD discards partial or pending results; no res_valid pulse follows.
REQ-026 First start after reset release behaves identically to a start after a completed handshake.

Verification
REQ-027 Memory model contents mem[k]=k, start pulse, res_ready=1 -> addr sequences 0..7, res_valid at E9, sum=28, max=7, busy low at E9.
REQ-028 All words 16'hFFFF -> sum=19'h7FFF8, max=16'hFFFF (no overflow).
REQ-029 Contents {5,9,2,9,0,1,3,8}, res_ready=0 for 6 cycles after res_valid -> sum=37, max=9 stable all 6 cycles; IDLE one edge after res_ready=1.
REQ-030 start re-pulsed during ISSUE at E3 and during HOLD -> no restart; addr sequence and results unchanged.
REQ-031 reset=1 at E4 of a scan -> next cycle busy=0, res_valid=0, addr=0, sum=0, max=0; subsequent start yields correct results.
REQ-032 start held high continuously, res_ready=1 -> back-to-back scans; each new scan starts one cycle after handshake, results correct each time.
